serial_or_reduce: RTL and testbench

//   Streaming OR-reduction stage that sits directly downstream of the mux-built
//   OR gate. It accepts WIDTH-bit beats over a valid/ready handshake and ORs

---
 rtl/serial_or_reduce_pkg.sv | 24 ++
 rtl/serial_or_reduce_or_gate_using_mux.sv | 19 +
 rtl/serial_or_reduce.sv | 163 ++++++++++++++++
 tb/tb_serial_or_reduce.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/serial_or_reduce_pkg.sv
// -----------------------------------------------------------------------------
// serial_or_reduce_pkg
//   Shared types for the serial OR-reduction stage.
//   - sor_state_t : frame-level state of the reduction stage
//       IDLE  : no beats of the current frame held, no result pending
//       ACCUM : at least one beat of the current frame held
//       HOLD  : a finished frame result is presented downstream
// -----------------------------------------------------------------------------
package serial_or_reduce_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } sor_state_t;

  // Single-bit OR expressed as a 2:1 mux: when a is set the output is forced
  // high, otherwise b passes through. Kept here so the gate and any checker
  // share one definition of the function.
  function automatic logic mux_or(input logic a, input logic b);
    mux_or = a ? 1'b1 : b;
  endfunction

endpackage : serial_or_reduce_pkg

// File: rtl/serial_or_reduce_or_gate_using_mux.sv
// -----------------------------------------------------------------------------
// or_gate_using_mux
//   Two-input OR gate built from a 2:1 multiplexer.
//   Ports:
//     a  in  1  select / first operand
//     b  in  1  second operand (passed through when a=0)
//     y  out 1  a | b
// -----------------------------------------------------------------------------
module or_gate_using_mux
  import serial_or_reduce_pkg::*;
(
  input  logic a,
  input  logic b,
  output logic y
);

  assign y = mux_or(a, b);

endmodule : or_gate_using_mux

// File: rtl/serial_or_reduce.sv
// -----------------------------------------------------------------------------
// serial_or_reduce
//   Streaming OR-reduction stage. WIDTH-bit beats arrive over valid/ready and
//   BEATS consecutive accepted beats are ORed bitwise into one frame result.
//   The result vector and its 1-bit reduction are held downstream until the
//   consumer takes them. A new frame may start in the same cycle the previous
//   result is consumed, so full streaming runs without bubbles.
//   Ports:
//     clk        in   1      clock, all state changes on posedge
//     rst        in   1      synchronous reset, active-high
//     up_valid   in   1      upstream beat valid
//     up_data    in   WIDTH  upstream beat data
//     up_ready   out  1      stage can take a beat this cycle
//     down_valid out  1      frame result valid
//     down_vec   out  WIDTH  bitwise OR of all beats of the frame
//     down_any   out  1      |down_vec
//     down_ready in   1      downstream accepts the result this cycle
// -----------------------------------------------------------------------------
module serial_or_reduce
  import serial_or_reduce_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int BEATS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  output logic             up_ready,
  output logic             down_valid,
  output logic [WIDTH-1:0] down_vec,
  output logic             down_any,
  input  logic             down_ready
);

  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  sor_state_t       state_r;
  sor_state_t       state_next_s;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] acc_r;
  logic             down_valid_r;
  logic [WIDTH-1:0] down_vec_r;
  logic             down_any_r;

  logic             up_ready_s;
  logic             accept_s;
  logic             emit_s;
  logic             consume_s;
  logic [WIDTH-1:0] acc_masked_s;
  logic [WIDTH-1:0] acc_next_s;

  // Handshake qualifiers. The only combinational input-to-output path is
  // down_ready -> up_ready, which lets a beat enter on the consume cycle.
  always_comb begin
    up_ready_s = 1'b0;
    accept_s   = 1'b0;
    emit_s     = 1'b0;
    consume_s  = 1'b0;
    up_ready_s = (state_r != HOLD) | down_ready;
    accept_s   = up_valid & up_ready_s;
    // cnt is 0 in IDLE and HOLD, so a single compare covers BEATS==1 as well
    emit_s     = accept_s & (cnt_r == CNT_LAST);
    consume_s  = down_valid_r & down_ready;
  end

  // The first beat of a frame must not inherit stale accumulator bits.
  always_comb begin
    acc_masked_s = {WIDTH{1'b0}};
    if (cnt_r == {CNT_W{1'b0}}) begin
      acc_masked_s = {WIDTH{1'b0}};
    end else begin
      acc_masked_s = acc_r;
    end
  end

  // Per-bit OR of the masked accumulator with the incoming beat.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_or
      or_gate_using_mux u_or (
        .a (acc_masked_s[gi]),
        .b (up_data[gi]),
        .y (acc_next_s[gi])
      );
    end
  endgenerate

  // Next-state decode for the frame FSM.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_next_s = emit_s ? HOLD : ACCUM;
        end else begin
          state_next_s = IDLE;
        end
      end
      ACCUM: begin
        if (accept_s) begin
          state_next_s = emit_s ? HOLD : ACCUM;
        end else begin
          state_next_s = ACCUM;
        end
      end
      HOLD: begin
        if (consume_s) begin
          // a beat accepted alongside the consume opens the next frame
          if (accept_s) begin
            state_next_s = emit_s ? HOLD : ACCUM;
          end else begin
            state_next_s = IDLE;
          end
        end else begin
          state_next_s = HOLD;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State, beat counter, accumulator and registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      cnt_r        <= {CNT_W{1'b0}};
      acc_r        <= {WIDTH{1'b0}};
      down_valid_r <= 1'b0;
      down_vec_r   <= {WIDTH{1'b0}};
      down_any_r   <= 1'b0;
    end else begin
      state_r <= state_next_s;

      if (emit_s) begin
        cnt_r      <= {CNT_W{1'b0}};
        acc_r      <= {WIDTH{1'b0}};
        down_vec_r <= acc_next_s;
        down_any_r <= |acc_next_s;
      end else if (accept_s) begin
        cnt_r <= cnt_r + CNT_ONE;
        acc_r <= acc_next_s;
      end

      // a fresh result wins over the consume of the previous one
      if (emit_s) begin
        down_valid_r <= 1'b1;
      end else if (consume_s) begin
        down_valid_r <= 1'b0;
      end
    end
  end

  assign up_ready   = up_ready_s;
  assign down_valid = down_valid_r;
  assign down_vec   = down_vec_r;
  assign down_any   = down_any_r;

endmodule : serial_or_reduce

// File: tb/tb_serial_or_reduce.sv
// -----------------------------------------------------------------------------
// tb_serial_or_reduce
//   Self-checking bench for serial_or_reduce (WIDTH=8, BEATS=4). A frame-level
//   reference model (queue of accepted beats, pending result flag) predicts
//   up_ready, down_valid, down_vec and down_any every cycle.
// -----------------------------------------------------------------------------
module tb_serial_or_reduce;

  localparam int WIDTH = 8;
  localparam int BEATS = 4;

  logic             clk;
  logic             rst;
  logic             up_valid;
  logic [WIDTH-1:0] up_data;
  logic             up_ready;
  logic             down_valid;
  logic [WIDTH-1:0] down_vec;
  logic             down_any;
  logic             down_ready;

  int tests;
  int fails;

  // reference model state
  logic [WIDTH-1:0] m_beats[$];
  bit               m_have;
  logic [WIDTH-1:0] m_vec;
  bit               m_known;
  int               m_results;

  serial_or_reduce #(.WIDTH(WIDTH), .BEATS(BEATS)) dut (
    .clk        (clk),
    .rst        (rst),
    .up_valid   (up_valid),
    .up_data    (up_data),
    .up_ready   (up_ready),
    .down_valid (down_valid),
    .down_vec   (down_vec),
    .down_any   (down_any),
    .down_ready (down_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                       input logic [WIDTH-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check up_ready before the edge, advance
  // the model at the edge, check outputs just after it.
  task automatic step(input logic v, input logic [WIDTH-1:0] d,
                      input logic dr, input logic r);
    bit               acc;
    logic [WIDTH-1:0] orv;
    up_valid   = v;
    up_data    = d;
    down_ready = dr;
    rst        = r;
    #1;
    if (m_known) check("up_ready", {7'd0, up_ready}, {7'd0, (!m_have) | dr});
    @(posedge clk);
    if (r) begin
      m_beats.delete();
      m_have  = 1'b0;
      m_vec   = '0;
      m_known = 1'b1;
    end else begin
      acc = v && (!m_have || dr);
      if (m_have && dr) m_have = 1'b0;
      if (acc) m_beats.push_back(d);
      if (m_beats.size() == BEATS) begin
        orv = '0;
        foreach (m_beats[i]) orv = orv | m_beats[i];
        m_vec  = orv;
        m_have = 1'b1;
        m_results++;
        m_beats.delete();
      end
    end
    #1;
    check("down_valid", {7'd0, down_valid}, {7'd0, m_have});
    if (m_have || r) begin
      check("down_vec", down_vec, m_vec);
      check("down_any", {7'd0, down_any}, {7'd0, |m_vec});
    end
  endtask

  initial begin
    int r0;
    tests = 0; fails = 0;
    m_have = 1'b0; m_vec = '0; m_known = 1'b0; m_results = 0;
    up_valid = 1'b0; up_data = '0; down_ready = 1'b1; rst = 1'b1;

    // 1. reset
    step(1'b0, 8'h00, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    check("rst_valid", {7'd0, down_valid}, 8'h00);
    check("rst_vec", down_vec, 8'h00);
    check("rst_any", {7'd0, down_any}, 8'h00);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("rst_up_ready", {7'd0, up_ready}, 8'h01);

    // 2. basic frame, one-cycle result
    step(1'b1, 8'h01, 1'b1, 1'b0);
    step(1'b1, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'h10, 1'b1, 1'b0);
    step(1'b1, 8'h80, 1'b1, 1'b0);
    check("t2_valid", {7'd0, down_valid}, 8'h01);
    check("t2_vec", down_vec, 8'h91);
    check("t2_any", {7'd0, down_any}, 8'h01);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("t2_one_cycle", {7'd0, down_valid}, 8'h00);

    // 3. all-zero frame
    for (int i = 0; i < 4; i++) step(1'b1, 8'h00, 1'b1, 1'b0);
    check("t3_valid", {7'd0, down_valid}, 8'h01);
    check("t3_vec", down_vec, 8'h00);
    check("t3_any", {7'd0, down_any}, 8'h00);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // 4. backpressure, then consume + new beat in the same cycle
    step(1'b1, 8'h01, 1'b0, 1'b0);
    step(1'b1, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'h10, 1'b0, 1'b0);
    step(1'b1, 8'h80, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'h55, 1'b0, 1'b0);
      check("t4_hold_ready", {7'd0, up_ready}, 8'h00);
      check("t4_hold_vec", down_vec, 8'h91);
    end
    step(1'b1, 8'h02, 1'b1, 1'b0);
    check("t4_consumed", {7'd0, down_valid}, 8'h00);
    for (int i = 0; i < 3; i++) step(1'b1, 8'h00, 1'b1, 1'b0);
    check("t4_vec", down_vec, 8'h02);
    check("t4_valid", {7'd0, down_valid}, 8'h01);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // 5. gapped valids
    r0 = m_results;
    step(1'b1, 8'h01, 1'b1, 1'b0);
    step(1'b0, 8'hFF, 1'b1, 1'b0);
    step(1'b1, 8'h02, 1'b1, 1'b0);
    step(1'b0, 8'hFF, 1'b1, 1'b0);
    step(1'b1, 8'h04, 1'b1, 1'b0);
    step(1'b0, 8'hFF, 1'b1, 1'b0);
    check("t5_early", {7'd0, down_valid}, 8'h00);
    step(1'b1, 8'h08, 1'b1, 1'b0);
    check("t5_vec", down_vec, 8'h0F);
    check("t5_valid", {7'd0, down_valid}, 8'h01);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("t5_count", 8'(m_results - r0), 8'h01);

    // 6. reset mid-frame discards partial beats
    step(1'b1, 8'hFF, 1'b1, 1'b0);
    step(1'b1, 8'hFF, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    step(1'b1, 8'h01, 1'b1, 1'b0);
    step(1'b1, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'h00, 1'b1, 1'b0);
    check("t6_vec", down_vec, 8'h01);
    check("t6_any", {7'd0, down_any}, 8'h01);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
           (($urandom_range(0, 3) == 0) ? 8'(1 << $urandom_range(0, 7))
                                         : 8'($urandom)),
           ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_serial_or_reduce
